mod8_count_gen: RTL and testbench

Upstream source for the `display7` seven-segment decoder. It generates the 4-bit digit value for that decoder from the fast board clock. A free-running prescaler produces a one-cycle update strobe. A mod-8 up/down counter with enable and synchronous load advances on each strobe. `oCount` connects directly to the decoder's `iData`. `oCarry` is available to cascade a second digit.

---
 rtl/mod8_count_gen_pkg.sv | 28 ++
 rtl/mod8_count_gen_tick_gen.sv | 34 +++
 rtl/mod8_count_gen.sv | 64 ++++++
 tb/tb_mod8_count_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod8_count_gen_pkg.sv
// Shared constants for the digit counter and its prescaler.
// Also reused by the display-scan blocks.
package mod8_count_gen_pkg;

   localparam int          CLK_HZ   = 100_000_000;
   localparam int          DIGIT_W  = 4;
   localparam logic [2:0]  MOD8_MAX = 3'd7;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   function automatic logic [2:0] mod8_next(
      input logic [2:0] v,
      input dir_e       dir
   );
      return (dir == DIR_UP) ? v + 3'd1 : v - 3'd1;
   endfunction

   function automatic logic mod8_wraps(
      input logic [2:0] v,
      input dir_e       dir
   );
      return (dir == DIR_UP) ? (v == MOD8_MAX) : (v == 3'd0);
   endfunction

endpackage

// File: rtl/mod8_count_gen_tick_gen.sv
// Free-running prescaler: one-cycle strobe every DIV clocks.
// oTick is decoded combinationally from the period counter.
module tick_gen #(
   parameter int DIV   = 100_000_000,
   parameter int DIV_W = 27
) (
   input  logic iClk,
   input  logic iRst_n,
   output logic oTick
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;

   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      if (div_cnt_q == LAST) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign oTick = (div_cnt_q == LAST);

endmodule

// File: rtl/mod8_count_gen.sv
// Mod-8 up/down digit counter advanced by a prescaler strobe.
// Feeds display7 directly; oCarry cascades to a second digit.
module mod8_count_gen
   import mod8_count_gen_pkg::*;
#(
   parameter int DIV   = CLK_HZ,
   parameter int DIV_W = 27
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iEn,
   input  logic               iUp,
   input  logic               iLoad,
   input  logic [2:0]         iLoadVal,
   output logic [DIGIT_W-1:0] oCount,
   output logic               oTick,
   output logic               oCarry
);

   logic [2:0] count_q;
   logic [2:0] count_d;
   logic       carry_q;
   logic       carry_d;
   logic       tick;
   dir_e       dir;

   tick_gen #(
      .DIV   (DIV),
      .DIV_W (DIV_W)
   ) u_tick (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .oTick  (tick)
   );

   assign dir = iUp ? DIR_UP : DIR_DOWN;

   // Load beats a coincident tick; that tick's update is dropped.
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      if (iLoad) begin
         count_d = iLoadVal;
      end else if (tick && iEn) begin
         count_d = mod8_next(count_q, dir);
         carry_d = mod8_wraps(count_q, dir);
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         count_q <= 3'd0;
         carry_q <= 1'b0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
      end
   end

   assign oCount = {1'b0, count_q};
   assign oTick  = tick;
   assign oCarry = carry_q;

endmodule

// File: tb/tb_mod8_count_gen.sv
// Bench for mod8_count_gen: DIV=4 and DIV=1 builds side by side,
// compared against an edge-counting arithmetic model.
module tb_mod8_count_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       ld;
   logic [2:0] ldv;
   logic [3:0] cnt4;
   logic       tick4;
   logic       car4;
   logic [3:0] cnt1;
   logic       tick1;
   logic       car1;

   int tests = 0;
   int fails = 0;

   int m_n[2];
   int m_cnt[2];
   bit m_car[2];
   int divs[2] = '{4, 1};

   mod8_count_gen #(.DIV(4), .DIV_W(3)) u4 (
      .iClk(clk), .iRst_n(rst_n), .iEn(en), .iUp(up),
      .iLoad(ld), .iLoadVal(ldv),
      .oCount(cnt4), .oTick(tick4), .oCarry(car4)
   );

   mod8_count_gen #(.DIV(1), .DIV_W(1)) u1 (
      .iClk(clk), .iRst_n(rst_n), .iEn(en), .iUp(up),
      .iLoad(ld), .iLoadVal(ldv),
      .oCount(cnt1), .oTick(tick1), .oCarry(car1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit exp_tick(int k);
      return ((m_n[k] + 1) % divs[k]) == 0;
   endfunction

   // Model: m_n counts edges since reset; edge n carries a tick when n%DIV==0.
   task automatic step();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_n[k] = 0;
            m_cnt[k] = 0;
            m_car[k] = 0;
         end else begin
            m_n[k]++;
            if (ld) begin
               m_cnt[k] = int'(ldv);
               m_car[k] = 0;
            end else if (en && (m_n[k] % divs[k] == 0)) begin
               if (up) begin
                  m_car[k] = (m_cnt[k] == 7);
                  m_cnt[k] = (m_cnt[k] + 1) % 8;
               end else begin
                  m_car[k] = (m_cnt[k] == 0);
                  m_cnt[k] = (m_cnt[k] + 7) % 8;
               end
            end else begin
               m_car[k] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; up = 1'b1; ld = 1'b0; ldv = 3'd0;
      step();
      step();
      tests++;
      if (cnt4 !== 4'd0 || car4 !== 1'b0 || tick4 !== 1'b0) begin
         fails++;
         $display("FAIL reset: count=%0d carry=%b tick=%b, want 0 0 0",
                  cnt4, car4, tick4);
      end
      tests++;
      if (cnt1 !== 4'd0 || car1 !== 1'b0) begin
         fails++;
         $display("FAIL reset_div1: count=%0d carry=%b, want 0 0",
                  cnt1, car1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_up_count();
      en = 1'b1; up = 1'b1; ld = 1'b0;
      do_reset();
      for (int i = 1; i <= 40; i++) begin
         step();
         tests++;
         if (cnt4 !== 4'(m_cnt[0]) || car4 !== m_car[0]
             || tick4 !== exp_tick(0)) begin
            fails++;
            $display("FAIL up_count e%0d: count=%0d carry=%b tick=%b, want %0d %b %b",
                     i, cnt4, car4, tick4, m_cnt[0], m_car[0], exp_tick(0));
         end
         if (i == 32) begin
            tests++;
            if (cnt4 !== 4'd0 || car4 !== 1'b1) begin
               fails++;
               $display("FAIL up_wrap: count=%0d carry=%b, want 0 1",
                        cnt4, car4);
            end
         end
         if (i == 33) begin
            tests++;
            if (car4 !== 1'b0) begin
               fails++;
               $display("FAIL up_carry_width: carry=%b, want 0", car4);
            end
         end
      end
   endtask

   task automatic test_down_count();
      en = 1'b1; up = 1'b0; ld = 1'b0;
      do_reset();
      for (int i = 1; i <= 36; i++) begin
         step();
         tests++;
         if (cnt4 !== 4'(m_cnt[0]) || car4 !== m_car[0]) begin
            fails++;
            $display("FAIL down_count e%0d: count=%0d carry=%b, want %0d %b",
                     i, cnt4, car4, m_cnt[0], m_car[0]);
         end
         if (i == 4 || i == 36) begin
            tests++;
            if (cnt4 !== 4'd7 || car4 !== 1'b1) begin
               fails++;
               $display("FAIL down_borrow e%0d: count=%0d carry=%b, want 7 1",
                        i, cnt4, car4);
            end
         end
      end
   endtask

   task automatic test_enable_gap();
      en = 1'b1; up = 1'b1; ld = 1'b0;
      do_reset();
      for (int i = 1; i <= 12; i++) begin
         en = (i >= 5 && i <= 8) ? 1'b0 : 1'b1;
         step();
         if (i == 8 || i == 11) begin
            tests++;
            if (cnt4 !== 4'd1) begin
               fails++;
               $display("FAIL enable_hold e%0d: count=%0d, want 1", i, cnt4);
            end
         end
         if (i == 12) begin
            tests++;
            if (cnt4 !== 4'd2) begin
               fails++;
               $display("FAIL enable_resume: count=%0d, want 2", cnt4);
            end
         end
      end
      en = 1'b1;
   endtask

   task automatic test_load_on_tick();
      en = 1'b1; up = 1'b1; ld = 1'b0;
      do_reset();
      repeat (3) step();
      tests++;
      if (tick4 !== 1'b1) begin
         fails++;
         $display("FAIL load_tick_pre: tick=%b, want 1", tick4);
      end
      ld = 1'b1; ldv = 3'd5;
      step();
      ld = 1'b0;
      tests++;
      if (cnt4 !== 4'd5 || car4 !== 1'b0) begin
         fails++;
         $display("FAIL load_wins: count=%0d carry=%b, want 5 0", cnt4, car4);
      end
      repeat (3) step();
      tests++;
      if (cnt4 !== 4'd5) begin
         fails++;
         $display("FAIL load_hold: count=%0d, want 5", cnt4);
      end
      step();
      tests++;
      if (cnt4 !== 4'd6) begin
         fails++;
         $display("FAIL load_next: count=%0d, want 6", cnt4);
      end
   endtask

   task automatic test_mid_reset();
      en = 1'b1; up = 1'b1; ld = 1'b0;
      do_reset();
      repeat (14) step();
      tests++;
      if (cnt4 !== 4'd3) begin
         fails++;
         $display("FAIL mid_reset_pre: count=%0d, want 3", cnt4);
      end
      do_reset();
      tests++;
      if (cnt4 !== 4'd0 || tick4 !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: count=%0d tick=%b, want 0 0", cnt4, tick4);
      end
      repeat (3) step();
      tests++;
      if (cnt4 !== 4'd0) begin
         fails++;
         $display("FAIL mid_reset_hold: count=%0d, want 0", cnt4);
      end
      step();
      tests++;
      if (cnt4 !== 4'd1) begin
         fails++;
         $display("FAIL mid_reset_first: count=%0d, want 1", cnt4);
      end
   endtask

   task automatic test_div1();
      en = 1'b1; up = 1'b1; ld = 1'b0;
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         step();
         tests++;
         if (cnt1 !== 4'(i % 8) || car1 !== (i % 8 == 0)
             || tick1 !== 1'b1) begin
            fails++;
            $display("FAIL div1_up e%0d: count=%0d carry=%b tick=%b, want %0d %b 1",
                     i, cnt1, car1, tick1, i % 8, (i % 8 == 0));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         en = ($urandom_range(0, 3) != 0);
         up = 1'($urandom);
         ld = ($urandom_range(0, 9) == 0);
         ldv = 3'($urandom);
         step();
         tests++;
         if (cnt4 !== 4'(m_cnt[0]) || car4 !== m_car[0]
             || tick4 !== exp_tick(0)) begin
            fails++;
            $display("FAIL random_div4 #%0d: count=%0d carry=%b tick=%b, want %0d %b %b",
                     i, cnt4, car4, tick4, m_cnt[0], m_car[0], exp_tick(0));
         end
         tests++;
         if (cnt1 !== 4'(m_cnt[1]) || car1 !== m_car[1]) begin
            fails++;
            $display("FAIL random_div1 #%0d: count=%0d carry=%b, want %0d %b",
                     i, cnt1, car1, m_cnt[1], m_car[1]);
         end
      end
      rst_n = 1'b1; ld = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; ldv = 3'd0;
      test_reset();
      test_up_count();
      test_down_count();
      test_enable_gap();
      test_load_on_tick();
      test_mid_reset();
      test_div1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
